// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// The fetch stage is the master: it raises imem_req with imem_addr, and the
// memory answers with imem_ready and imem_rdata in the same cycle.
interface if_fetch_stage_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches over the imem handshake, and loads the IF/ID register.
// ST_REQ issues a fetch at pc, ST_HELD parks one fetched instruction in a
// skid buffer while decode is stalled, and ST_DRAIN keeps an unaccepted
// request alive after a redirect so the handshake is never withdrawn.
module if_fetch_stage #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   PCSrc,
    input  logic                   Jump,
    input  logic [PC_WIDTH-1:0]    BranchTarget,
    input  logic [PC_WIDTH-1:0]    JumpTarget,
    input  logic                   IFIDflush,
    input  logic                   stall,
    if_fetch_stage_if.master       imem,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc4,
    output logic                   ifid_valid
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   redirect;
    logic [PC_WIDTH-1:0]    target;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    redirect_pc_next;

    logic [INSTR_WIDTH-1:0] buf_instr;
    logic [PC_WIDTH-1:0]    buf_pc4;
    logic                   buf_load;
    logic                   ifid_load_fetch;
    logic                   ifid_load_buf;

    // The branch is the older instruction, so it beats a simultaneous jump.
    assign redirect = PCSrc | Jump;
    assign target   = PCSrc ? BranchTarget : JumpTarget;
    // Wraps modulo 2^PC_WIDTH by construction.
    assign pc_plus4 = pc + PC_WIDTH'(4);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection from the handshake, stall and redirect.
    // NOTE: a default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_REQ: begin
                if (redirect) begin
                    state_next = imem.imem_ready ? ST_REQ : ST_DRAIN;
                end else if (imem.imem_ready && stall) begin
                    state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (redirect || !stall) begin
                    state_next = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_ready) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_REQ;
        endcase
    end

    // Outputs and datapath controls; imem_addr is pure pc, never imem_ready.
    always_comb begin
        imem.imem_req    = rst_n && (state != ST_HELD);
        imem.imem_addr   = pc;
        pc_next          = pc;
        redirect_pc_next = redirect_pc;
        buf_load         = 1'b0;
        ifid_load_fetch  = 1'b0;
        ifid_load_buf    = 1'b0;
        unique case (state)
            ST_REQ: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        pc_next = target;
                    end else begin
                        redirect_pc_next = target;
                    end
                end else if (imem.imem_ready) begin
                    pc_next = pc_plus4;
                    if (stall) begin
                        buf_load = 1'b1;
                    end else begin
                        ifid_load_fetch = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (redirect) begin
                    pc_next = target;
                end else if (!stall) begin
                    ifid_load_buf = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    redirect_pc_next = target;
                end
                if (imem.imem_ready) begin
                    pc_next = redirect ? target : redirect_pc;
                end
            end
            default: ;
        endcase
    end

    // PC and pending-redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            redirect_pc <= RESET_PC;
        end else begin
            pc          <= pc_next;
            redirect_pc <= redirect_pc_next;
        end
    end

    // Skid buffer capture when a fetch completes under stall.
    // NOTE: buffer data is not reset; being in ST_HELD alone marks it occupied.
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_instr <= imem.imem_rdata;
            buf_pc4   <= pc_plus4;
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (IFIDflush || redirect) begin
            ifid_valid <= 1'b0;
        end else if (stall) begin
            ifid_valid <= ifid_valid;
        end else if (ifid_load_fetch) begin
            ifid_instr <= imem.imem_rdata;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
        end else if (ifid_load_buf) begin
            ifid_instr <= buf_instr;
            ifid_pc4   <= buf_pc4;
            ifid_valid <= 1'b1;
        end else begin
            ifid_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios plus randomized traffic.
// The reference model is the architectural instruction stream: consecutive
// word addresses from the last reset or redirect target. Decode consumes an
// IF/ID entry on any cycle where it is valid and not stalled, flushed or
// redirected; each consumption is compared with the head of that stream.
module tb_if_fetch_stage;

    localparam int unsigned PW       = 32;
    localparam int unsigned IW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        PCSrc        = 1'b0;
    logic        Jump         = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] JumpTarget   = '0;
    logic        IFIDflush    = 1'b0;
    logic        stall        = 1'b0;
    logic        ready_drv    = 1'b0;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    int          checks   = 0;
    int          errors   = 0;
    int          consumed = 0;
    exp_t        exp_q[$];

    if_fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) imem ();

    if_fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCSrc        (PCSrc),
        .Jump         (Jump),
        .BranchTarget (BranchTarget),
        .JumpTarget   (JumpTarget),
        .IFIDflush    (IFIDflush),
        .stall        (stall),
        .imem         (imem),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a bijection of the address, so every
    // instruction identifies where it came from.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem.imem_ready = ready_drv;
    assign imem.imem_rdata = ready_drv ? mem_word(imem.imem_addr) : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        exp_q.push_back('{pc: start, instr: mem_word(start)});
    endtask

    task automatic top_up();
        logic [31:0] nxt;
        while (exp_q.size() < 4) begin
            nxt = exp_q[exp_q.size()-1].pc + 32'd4;
            exp_q.push_back('{pc: nxt, instr: mem_word(nxt)});
        end
    endtask

    // Applies inputs for the coming rising edge and updates the reference stream.
    task automatic drive(input logic r, input logic rdy, input logic st,
                         input logic ps, input logic jp, input logic fl,
                         input logic [31:0] bt, input logic [31:0] jt);
        rst_n        = r;
        ready_drv    = rdy;
        stall        = st;
        PCSrc        = ps;
        Jump         = jp;
        IFIDflush    = fl;
        BranchTarget = bt;
        JumpTarget   = jt;
        if (!r) begin
            restart_stream(RESET_PC);
        end else if (ps || jp) begin
            restart_stream(ps ? bt : jt);
        end
        top_up();
    endtask

    task automatic idle(input logic rdy);
        drive(1'b1, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_target();
        if ($urandom_range(0, 3) == 0) begin
            return 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        end
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    // Monitor: handshake rules and in-order delivery against the stream.
    logic        prev_rst   = 1'b0;
    logic        prev_req   = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_addr  = '0;
    exp_t        head;

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (prev_rst && prev_req && !prev_ready) begin
                check("hs_req_held", 32'(imem.imem_req), 32'd1);
                check("hs_addr_stable", imem.imem_addr, prev_addr);
            end
            if (ifid_valid && !stall && !IFIDflush && !PCSrc && !Jump) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got pc4 %h with empty stream", ifid_pc4);
                end else begin
                    head = exp_q.pop_front();
                    check("sb_pc4", ifid_pc4, head.pc + 32'd4);
                    check("sb_instr", ifid_instr, head.instr);
                    consumed++;
                end
            end
        end
        prev_rst   = rst_n;
        prev_req   = imem.imem_req;
        prev_ready = ready_drv;
        prev_addr  = imem.imem_addr;
    end

    int          base_consumed;
    logic        r_rst;
    logic        r_rdy;
    logic        r_st;
    logic        r_redir;
    logic        r_ps;
    logic        r_jp;
    logic        r_fl;

    initial begin
        // Reset and zero-wait streaming from RESET_PC.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        check("rst_req_low", 32'(imem.imem_req), 32'd0);
        check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_ifid_pc4", ifid_pc4, 32'd0);
        check("rst_ifid_instr", ifid_instr, 32'd0);
        idle(1'b1);
        #1;
        check("first_req", 32'(imem.imem_req), 32'd1);
        check("first_addr", imem.imem_addr, RESET_PC);
        cyc();
        check("s1_valid", 32'(ifid_valid), 32'd1);
        check("s1_pc4", ifid_pc4, 32'd4);
        check("s1_addr", imem.imem_addr, 32'd4);
        idle(1'b1);
        cyc();
        check("s2_pc4", ifid_pc4, 32'd8);
        check("s2_addr", imem.imem_addr, 32'd8);

        // Three wait states on address 8.
        idle(1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("wait_addr", imem.imem_addr, 32'd8);
            check("wait_req", 32'(imem.imem_req), 32'd1);
            check("wait_bubble", 32'(ifid_valid), 32'd0);
            idle(k == 2);
        end
        cyc();
        check("after_wait_valid", 32'(ifid_valid), 32'd1);
        check("after_wait_pc4", ifid_pc4, 32'd12);
        check("after_wait_instr", ifid_instr, mem_word(32'd8));
        idle(1'b1);
        cyc();
        check("pre_stall_addr", imem.imem_addr, 32'h10);

        // Two-cycle stall while address 0x10 completes.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("held_req_low", 32'(imem.imem_req), 32'd0);
            check("held_ifid_pc4", ifid_pc4, 32'h10);
            check("held_ifid_valid", 32'(ifid_valid), 32'd1);
            drive(1'b1, 1'b1, k == 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        cyc();
        check("unheld_pc4", ifid_pc4, 32'h14);
        check("unheld_instr", ifid_instr, mem_word(32'h10));
        check("unheld_addr", imem.imem_addr, 32'h14);
        idle(1'b1);
        cyc();
        check("post_held_pc4", ifid_pc4, 32'h18);

        // Branch while memory is not ready: drain the old request first.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        cyc();
        check("drain_addr", imem.imem_addr, 32'h18);
        check("drain_req", 32'(imem.imem_req), 32'd1);
        check("drain_flush", 32'(ifid_valid), 32'd0);
        idle(1'b0);
        cyc();
        check("drain_addr2", imem.imem_addr, 32'h18);
        check("drain_bubble", 32'(ifid_valid), 32'd0);
        idle(1'b1);
        cyc();
        check("drained_addr", imem.imem_addr, 32'h40);
        check("drained_bubble", 32'(ifid_valid), 32'd0);
        idle(1'b1);
        cyc();
        check("br_valid", 32'(ifid_valid), 32'd1);
        check("br_pc4", ifid_pc4, 32'h44);
        check("br_instr", ifid_instr, mem_word(32'h40));

        // Branch and jump together: the branch wins.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h80);
        cyc();
        check("prio_addr", imem.imem_addr, 32'h40);
        check("prio_bubble", 32'(ifid_valid), 32'd0);
        idle(1'b1);
        cyc();
        check("prio_pc4", ifid_pc4, 32'h44);
        // Stall with flush: the instruction from 0x40 is killed in IF/ID.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        void'(exp_q.pop_front());
        cyc();
        check("stall_flush_valid", 32'(ifid_valid), 32'd0);
        idle(1'b1);
        cyc();
        check("after_flush_pc4", ifid_pc4, 32'h48);
        check("after_flush_valid", 32'(ifid_valid), 32'd1);

        // Reset in the middle of a drain forgets the pending target.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        check("mid_rst_req_low", 32'(imem.imem_req), 32'd0);
        idle(1'b1);
        #1;
        check("mid_rst_addr", imem.imem_addr, RESET_PC);
        check("mid_rst_valid", 32'(ifid_valid), 32'd0);
        cyc();
        check("mid_rst_pc4", ifid_pc4, RESET_PC + 32'd4);
        check("mid_rst_next_addr", imem.imem_addr, RESET_PC + 32'd4);

        // PC wrap at the top of the address space.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF8);
        cyc();
        idle(1'b1);
        cyc();
        idle(1'b1);
        cyc();
        check("wrap_addr", imem.imem_addr, 32'h0);
        check("wrap_pc4", ifid_pc4, 32'h0);

        // Randomized traffic.
        base_consumed = consumed;
        for (int i = 0; i < 4000; i++) begin
            r_rst   = ($urandom_range(0, 499) != 0);
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_st    = ($urandom_range(0, 4) == 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_ps    = r_redir && ($urandom_range(0, 1) == 1);
            r_jp    = r_redir && (!r_ps || ($urandom_range(0, 1) == 1));
            r_fl    = r_redir && ($urandom_range(0, 1) == 1);
            drive(r_rst, r_rdy, r_st, r_ps, r_jp, r_fl, pick_target(), pick_target());
            cyc();
        end
        idle(1'b1);
        repeat (4) cyc();
        check("random_progress", 32'(consumed - base_consumed >= 500), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
